// File: rtl/dualmem_stream_reader.sv
// -----------------------------------------------------------------------------
// dualmem_stream_reader
//
// Sequential read engine for port B of a 512 x 64-bit dual-port block RAM.
// A command (start address, word count) is turned into back-to-back
// single-word RAM reads. The RAM's fixed one-cycle read latency is absorbed
// by a small skid FIFO. Words leave on a valid/ready stream that carries a
// last flag.
//
// Ports
//   clk        sole clock; RAM port B runs from the same clock
//   rstn       asynchronous active-low reset
//   cmd_valid  command request
//   cmd_ready  high only while idle
//   cmd_addr   start word address
//   cmd_len    word count, 0..512 (larger values behave modulo 1024)
//   abort      synchronous cancel of the running command
//   mem_en     RAM enb
//   mem_we     RAM web, tied to zero
//   mem_addr   RAM addrb
//   mem_rdata  RAM doutb, valid the cycle after mem_en
//   out_valid  stream word valid
//   out_ready  consumer accept
//   out_data   stream word (zero while out_valid is low)
//   out_last   final word of the command
//   busy       command in progress (state != IDLE)
//   done       one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module dualmem_stream_reader #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [ADDR_W:0]     cmd_len,
    input  logic                abort,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_last,
    output logic                busy,
    output logic                done
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t state, state_nxt;

    // Read issue side
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   issue_cnt;
    logic              inflight;       // a read was issued last cycle
    logic              inflight_last;  // that read is the command's final word

    // Skid FIFO
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [DEPTH-1:0]  fifo_last;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;

    logic              accept;
    logic              kill;
    logic              push;
    logic              pop;
    logic [CNT_W:0]    occ_after_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign accept = cmd_valid && cmd_ready;
    assign kill   = abort && (state == RUN);
    assign pop    = out_valid && out_ready;
    // A read returning this cycle is dropped if the command is being aborted.
    assign push   = inflight && !kill;

    // Words that will occupy the FIFO once this cycle's pop and the read in
    // flight have settled. Counting the pop lets a stalled stream resume
    // issuing in the same cycle out_ready returns.
    assign occ_after_pop = {1'b0, fifo_cnt}
                         + {{CNT_W{1'b0}}, inflight}
                         - {{CNT_W{1'b0}}, pop};

    assign mem_en   = (state == RUN) && !abort && (issue_cnt != '0)
                   && (occ_after_pop < (CNT_W+1)'(DEPTH));
    assign mem_addr = rd_addr;
    assign mem_we   = '0;

    assign out_valid = (fifo_cnt != '0);
    assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
    assign out_last  = out_valid && fifo_last[rd_ptr];

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt = state;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_nxt = (cmd_len == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (pop && out_last) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Read issue
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_addr       <= '0;
            issue_cnt     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight <= mem_en;
            if (mem_en) begin
                inflight_last <= (issue_cnt == (ADDR_W+1)'(1));
            end
            if (accept) begin
                rd_addr   <= cmd_addr;
                issue_cnt <= cmd_len;
            end else if (kill) begin
                issue_cnt <= '0;
            end else if (mem_en) begin
                rd_addr   <= rd_addr + 1'b1;  // wraps at the top of the RAM
                issue_cnt <= issue_cnt - 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Skid FIFO
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (kill) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // NOTE: the storage array has no reset; an entry is only observed after
    // it has been written, and out_data is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= mem_rdata;
            fifo_last[wr_ptr] <= inflight_last;
        end
    end

endmodule

// File: tb/tb_dualmem_stream_reader.sv
// -----------------------------------------------------------------------------
// Testbench for dualmem_stream_reader. A behavioural RAM model drives
// mem_rdata. Stimulus pushes expected words into a scoreboard queue; a
// monitor on the falling edge pops and compares every accepted stream beat,
// and also checks stall stability, buffer occupancy and mem_we.
// -----------------------------------------------------------------------------
module tb_dualmem_stream_reader;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 2;
    localparam logic [DATA_W-1:0] BASE = 64'h1000_0000_0000_0000;

    logic                clk = 1'b0;
    logic                rstn;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [ADDR_W-1:0]   cmd_addr = '0;
    logic [ADDR_W:0]     cmd_len = '0;
    logic                abort = 1'b0;
    logic                mem_en;
    logic [DATA_W/8-1:0] mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_rdata = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [DATA_W-1:0]   out_data;
    logic                out_last;
    logic                busy;
    logic                done;

    dualmem_stream_reader #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .abort    (abort),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // RAM port B model: one-cycle read latency.
    logic [DATA_W-1:0] ram [512];
    initial begin
        for (int i = 0; i < 512; i++) ram[i] = BASE + 64'(i);
    end
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= ram[mem_addr];
    end

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t exp_q[$];
    int    tests = 0;
    int    fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Monitor / scoreboard
    // -------------------------------------------------------------------------
    int                outstanding = 0;
    logic              stall_prev = 1'b0;
    logic [DATA_W-1:0] stall_data = '0;
    logic              stall_last = 1'b0;
    beat_t             mon_exp;

    always @(negedge clk) begin
        if (!rstn) begin
            outstanding = 0;
            stall_prev  = 1'b0;
        end else begin
            check("mem_we", 64'(mem_we), 64'd0);
            check("occupancy", 64'(outstanding), (outstanding <= DEPTH) ? 64'(outstanding) : 64'(DEPTH));
            if (stall_prev && out_valid) begin
                check("stall_data", out_data, stall_data);
                check("stall_last", 64'(out_last), 64'(stall_last));
            end
            if (out_valid && out_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_beat: got data %h last %0b with no word expected",
                             out_data, out_last);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (out_data !== mon_exp.data || out_last !== mon_exp.last) begin
                        fails++;
                        $display("FAIL beat: got %h/%0b expected %h/%0b",
                                 out_data, out_last, mon_exp.data, mon_exp.last);
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            stall_last = out_last;
            if (abort && busy) outstanding = 0;
            else outstanding = outstanding + int'(mem_en) - int'(out_valid && out_ready);
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] addr, input int n, input int len);
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = addr + ADDR_W'(i);
            exp_q.push_back('{data: ram[a], last: (i == len - 1)});
        end
    endtask

    // Returns just after the accepting clock edge.
    task automatic issue(input logic [ADDR_W-1:0] addr, input logic [ADDR_W:0] len);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 500) begin
            tick();
            n++;
        end
        check(name, 64'(done), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_done"},      64'(done),      64'd0);
        check({tag, "_mem_en"},    64'(mem_en),    64'd0);
        check({tag, "_mem_we"},    64'(mem_we),    64'd0);
        check({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_last"},  64'(out_last),  64'd0);
        check({tag, "_out_data"},  out_data,       64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Directed tests
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0] wrap_addrs [4];
    logic              saw_done;

    initial begin
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #1 check_reset_outputs("reset0");
        repeat (3) tick();
        rstn = 1'b1;
        tick();

        // Basic read: addr 5, len 4, consumer always ready.
        out_ready = 1'b1;
        push_exp(9'd5, 4, 4);
        issue(9'd5, 10'd4);
        check("t1_p0_mem_en",    64'(mem_en),    64'd1);
        check("t1_p0_mem_addr",  64'(mem_addr),  64'h5);
        check("t1_p0_out_valid", 64'(out_valid), 64'd0);
        check("t1_p0_busy",      64'(busy),      64'd1);
        check("t1_p0_cmd_ready", 64'(cmd_ready), 64'd0);
        tick();
        check("t1_p1_out_valid", 64'(out_valid), 64'd0);
        tick();
        check("t1_p2_out_valid", 64'(out_valid), 64'd1);
        check("t1_p2_out_data",  out_data,       64'h1000_0000_0000_0005);
        check("t1_p2_out_last",  64'(out_last),  64'd0);
        tick();
        check("t1_p3_out_valid", 64'(out_valid), 64'd1);
        tick();
        check("t1_p4_out_valid", 64'(out_valid), 64'd1);
        check("t1_p4_out_last",  64'(out_last),  64'd0);
        tick();
        check("t1_p5_out_valid", 64'(out_valid), 64'd1);
        check("t1_p5_out_data",  out_data,       64'h1000_0000_0000_0008);
        check("t1_p5_out_last",  64'(out_last),  64'd1);
        check("t1_p5_done",      64'(done),      64'd0);
        tick();
        check("t1_p6_done",      64'(done),      64'd1);
        check("t1_p6_out_valid", 64'(out_valid), 64'd0);
        check("t1_p6_cmd_ready", 64'(cmd_ready), 64'd0);
        tick();
        check("t1_p7_done",      64'(done),      64'd0);
        check("t1_p7_cmd_ready", 64'(cmd_ready), 64'd1);
        check("t1_drained",      64'(exp_q.size()), 64'd0);

        // Address wrap: 0x1FE..0x001, issued without a gap.
        wrap_addrs[0] = 9'h1FE;
        wrap_addrs[1] = 9'h1FF;
        wrap_addrs[2] = 9'h000;
        wrap_addrs[3] = 9'h001;
        push_exp(9'h1FE, 4, 4);
        issue(9'h1FE, 10'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_mem_en_%0d", i),   64'(mem_en),   64'd1);
            check($sformatf("t2_mem_addr_%0d", i), 64'(mem_addr), 64'(wrap_addrs[i]));
            tick();
        end
        wait_done("t2_done");
        tick();
        check("t2_drained", 64'(exp_q.size()), 64'd0);

        // Zero-length command: done immediately, no RAM access, no beat.
        issue(9'd3, 10'd0);
        check("t3_p0_done",      64'(done),      64'd1);
        check("t3_p0_mem_en",    64'(mem_en),    64'd0);
        check("t3_p0_out_valid", 64'(out_valid), 64'd0);
        check("t3_p0_cmd_ready", 64'(cmd_ready), 64'd0);
        tick();
        check("t3_p1_done",      64'(done),      64'd0);
        check("t3_p1_mem_en",    64'(mem_en),    64'd0);
        check("t3_p1_out_valid", 64'(out_valid), 64'd0);
        check("t3_p1_cmd_ready", 64'(cmd_ready), 64'd1);

        // 16 words under pseudo-random backpressure.
        push_exp(9'd32, 16, 16);
        issue(9'd32, 10'd16);
        saw_done = 1'b0;
        for (int n = 0; n < 400 && !saw_done; n++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            if (done) saw_done = 1'b1;
        end
        out_ready = 1'b1;
        check("t4_done", 64'(saw_done), 64'd1);
        check("t4_drained", 64'(exp_q.size()), 64'd0);
        tick();

        // Abort after the third beat, following two stalled cycles.
        out_ready = 1'b0;
        push_exp(9'd100, 3, 10);
        issue(9'd100, 10'd10);
        repeat (3) tick();
        check("t5_full_valid",  64'(out_valid), 64'd1);
        check("t5_full_mem_en", 64'(mem_en),    64'd0);
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        repeat (2) tick();
        abort = 1'b1;
        #1 check("t5_abort_mem_en", 64'(mem_en), 64'd0);
        tick();
        abort = 1'b0;
        check("t5_cmd_ready", 64'(cmd_ready), 64'd1);
        check("t5_busy",      64'(busy),      64'd0);
        check("t5_done",      64'(done),      64'd0);
        check("t5_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t5_quiet_valid_%0d", i), 64'(out_valid), 64'd0);
            check($sformatf("t5_quiet_done_%0d", i),  64'(done),      64'd0);
            check($sformatf("t5_quiet_mem_en_%0d", i), 64'(mem_en),   64'd0);
        end
        check("t5_drained", 64'(exp_q.size()), 64'd0);

        // Fresh command after abort.
        push_exp(9'd7, 3, 3);
        issue(9'd7, 10'd3);
        wait_done("t6_done");
        tick();
        check("t6_drained", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset mid-stream.
        push_exp(9'd50, 8, 8);
        issue(9'd50, 10'd8);
        repeat (3) tick();
        @(negedge clk);
        #2;
        rstn = 1'b0;
        exp_q.delete();
        #1 check_reset_outputs("reset_mid");
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset_hold");
        rstn = 1'b1;
        tick();
        push_exp(9'd0, 2, 2);
        issue(9'd0, 10'd2);
        wait_done("t7_done");
        tick();
        check("t7_drained", 64'(exp_q.size()), 64'd0);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dualmem_stream_reader.md
# dualmem_stream_reader

Sequential read engine for port B of the 512 x 64-bit dual-port block RAM. It accepts a start address and word count, issues back-to-back single-word reads, and absorbs the RAM's fixed one-cycle read latency in a small skid FIFO. Words leave on a valid/ready stream with a last flag, so a consumer (DMA or serialiser) can drain the RAM contents at one word per cycle under arbitrary backpressure.

## Interface
- ADDR_W, 9, RAM word-address width (512 words).
- DATA_W, 64, RAM and stream data width.
- DEPTH, 2, skid FIFO entries; minimum 2, which is required for full throughput.
- clk  in  1  sole clock; RAM port B is clocked from the same clk.
- rstn  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_addr  in  ADDR_W  start word address.
- cmd_len  in  ADDR_W+1  word count, 0..512.
- abort  in  1  synchronous cancel of the running command.
- mem_en  out  1  to RAM enb.
- mem_we  out  DATA_W/8  to RAM web; constant 0.
- mem_addr  out  ADDR_W  to RAM addrb.
- mem_rdata  in  DATA_W  from RAM doutb; valid the cycle after mem_en.
- out_valid  out  1  stream word valid.
- out_ready  in  1  consumer accept.
- out_data  out  DATA_W  stream word.
- out_last  out  1  marks the final word of the command.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a command completes normally.

## Operation
- States: IDLE, RUN, FIN.
- IDLE → RUN on cmd_valid && cmd_ready with cmd_len != 0.
  - Latch rd_addr = cmd_addr, issue_cnt = cmd_len, beat_cnt = cmd_len.
- IDLE → FIN on an accepted command with cmd_len == 0. No RAM access and no stream beat.
- RUN issue rule:
  - mem_en = (issue_cnt != 0) && (fifo_cnt + inflight − pop < DEPTH), where pop = out_valid && out_ready.
  - mem_addr = rd_addr.
  - On issue: rd_addr increments modulo 2^ADDR_W (0x1FF wraps to 0x000); issue_cnt decrements.
  - Each issue also records last_tag = (issue_cnt == 1).
- inflight is a 1-bit register, set to mem_en each cycle. When inflight is set, mem_rdata and last_tag are pushed into the FIFO.
- FIFO head drives out_data and out_last. Words leave in address order, with no loss and no duplication.
- On each pop, beat_cnt decrements. The pop with out_last set moves the state RUN → FIN.
- FIN: done = 1 for exactly one cycle, then the state returns to IDLE.
- abort while in RUN:
  - Next state is IDLE and done stays 0.
  - FIFO is flushed and issue_cnt cleared.
  - A read in flight that cycle is discarded.
  - mem_en is forced 0 in the abort cycle.
- abort in IDLE or FIN is ignored.
- cmd_len > 512 is a protocol error; the block behaves as cmd_len mod 1024, with no check.
- A cmd_len of 512 reads the whole RAM once, starting at cmd_addr and wrapping.
- Reset (async, any state) returns outputs to these values:
  - cmd_ready=1, busy=0, done=0, mem_en=0, mem_addr=0, out_valid=0, out_last=0, out_data=0.
  - FIFO empty, inflight=0.
  - Reset mid-command drops the command silently.

## Timing
- Command accepted at clock edge E0 → RUN during cycle E0+1, with mem_en=1 and mem_addr=cmd_addr.
- First word: out_valid=1 from edge E0+2, i.e. 2 cycles of latency after acceptance.
- With out_ready held high: one word per cycle and no bubbles. The last beat of an N-word command appears at E0+N+1.
- done is high in the cycle after the last-beat handshake. cmd_ready rises the cycle after done, so the minimum command-to-command gap is 2 idle cycles.
- cmd_len == 0: FIN (done=1) in cycle E0+1.
- Backpressure: while out_ready=0, at most DEPTH words are buffered, and mem_en drops once fifo_cnt + inflight reaches DEPTH.
  - After out_ready returns high, output resumes the same cycle from the FIFO.
  - The next issue happens the same cycle, via the pop term.
- out_data and out_last stay stable while out_valid && !out_ready.
- mem_we is 0 in every cycle, including during reset.

## Test plan
- Preload RAM[i] = 0x1000_0000_0000_0000 + i. Command addr=5, len=4, out_ready=1 → data 0x…05..0x…08 on 4 consecutive cycles from E0+2; out_last only on the word for address 8; done pulse at E0+6.
- Command addr=0x1FE, len=4 → data from addresses 0x1FE, 0x1FF, 0x000, 0x001; mem_addr wraps with no gap.
- Command len=16 with out_ready toggling pseudo-randomly (50%):
  - all 16 words arrive in order, with no duplicates;
  - fifo_cnt + inflight never exceeds 2;
  - out_data is stable while stalled.
- Command len=0 → done at E0+1, no mem_en and no out_valid; the next command is accepted 2 cycles later.
- Command len=10, with abort asserted after the 3rd beat and out_ready held low for 2 cycles before that → no further out_valid; done stays 0; cmd_ready=1 the next cycle; a fresh command then runs correctly.
- Deassert rstn mid-stream (asynchronously, between edges) → all outputs take their reset values immediately; after release, a command addr=0, len=2 returns RAM[0] and RAM[1].
